// File: rtl/refresh_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : refresh_sequencer
// Purpose  : DRAM auto-refresh sequencer. Keeps a signed refresh credit
//            (+1 per tREFI tick, -1 per accepted REF). Decides when a refresh
//            must or may run, holds off the scheduler, closes open banks with
//            PREA, issues REF over a valid/ready handshake and enforces tRP
//            and tRFC.
// Option   : REFRESH_PULL_IN_EN -- when defined, REFs may be pulled in ahead
//            of schedule after IDLE_CYCLES idle cycles (credit down to
//            -MAX_PULLIN). When undefined, credit never drops below 0 and
//            there is no idle-run counter.
// Ports    : clk          controller clock
//            rst          asynchronous active-high reset
//            ref_tick_i   one-cycle pulse per tREFI
//            sched_idle_i scheduler has nothing in flight or pending
//            bank_open_i  per-bank open-row flags
//            hold_o       scheduler must not issue new commands
//            cmd_valid_o  refresh-path command request
//            cmd_ready_i  command generator accepts the command
//            cmd_is_ref_o 1 = REF, 0 = PREA
//            ref_busy_o   sequencer not in IDLE
//            credit_o     signed refresh credit
//            overflow_o   sticky: tick arrived while credit was saturated
// Revision : 1.0 - initial release
// ============================================================================
module refresh_sequencer #(
  parameter int NBANK        = 8,
  parameter int T_RP         = 6,
  parameter int T_RFC        = 88,
  parameter int MAX_POSTPONE = 8,
  parameter int MAX_PULLIN   = 8,
  parameter int IDLE_CYCLES  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ref_tick_i,
  input  logic              sched_idle_i,
  input  logic [NBANK-1:0]  bank_open_i,
  output logic              hold_o,
  output logic              cmd_valid_o,
  input  logic              cmd_ready_i,
  output logic              cmd_is_ref_o,
  output logic              ref_busy_o,
  output logic signed [4:0] credit_o,
  output logic              overflow_o
);

  localparam int CNT_MAX = (T_RFC > T_RP) ? T_RFC : T_RP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic signed [4:0] CREDIT_MAX = 5'(MAX_POSTPONE);
`ifdef REFRESH_PULL_IN_EN
  localparam logic signed [4:0] CREDIT_MIN = 5'(-MAX_PULLIN);
`else
  localparam logic signed [4:0] CREDIT_MIN = 5'sd0;
`endif

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DRAIN    = 3'd1,
    S_PREA     = 3'd2,
    S_WAIT_RP  = 3'd3,
    S_REF      = 3'd4,
    S_WAIT_RFC = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic signed [4:0] credit_q, credit_d;
  logic              overflow_q, overflow_d;
  logic              hold_q, hold_d;
  logic              valid_q, valid_d;
  logic              is_ref_q, is_ref_d;

  logic              ref_accept;
  logic              pullin_trig;

`ifdef REFRESH_PULL_IN_EN
  localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
  logic [IDLE_W-1:0] idle_q, idle_d;

  // Counts consecutive idle cycles spent in IDLE; saturates at IDLE_CYCLES.
  always_comb begin
    idle_d = idle_q;
    if (!sched_idle_i || (state_q != S_IDLE)) begin
      idle_d = '0;
    end else if (idle_q != IDLE_W'(IDLE_CYCLES)) begin
      idle_d = idle_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idle_q <= '0;
    else     idle_q <= idle_d;
  end

  // The current idle cycle completes the run when IDLE_CYCLES-1 already
  // preceded it.
  assign pullin_trig = sched_idle_i && (credit_q > CREDIT_MIN) &&
                       (idle_q >= IDLE_W'(IDLE_CYCLES - 1));
`else
  assign pullin_trig = 1'b0;
`endif

  assign ref_accept = (state_q == S_REF) && cmd_ready_i;

  // Credit: simultaneous tick and REF acceptance cancel out.
  always_comb begin
    credit_d   = credit_q;
    overflow_d = overflow_q;
    if (ref_tick_i && !ref_accept) begin
      if (credit_q == CREDIT_MAX) overflow_d = 1'b1;
      else                        credit_d   = credit_q + 5'sd1;
    end else if (!ref_tick_i && ref_accept) begin
      if (credit_q > CREDIT_MIN)  credit_d   = credit_q - 5'sd1;
    end
  end

  // Next state. The wait counters are loaded with T-1 and the wait state
  // exits on the cycle it reads 0, so each wait state lasts exactly T cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if ((credit_q == CREDIT_MAX) ||
            ((credit_q >= 5'sd1) && sched_idle_i) ||
            pullin_trig) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (sched_idle_i) begin
          state_d = (bank_open_i != '0) ? S_PREA : S_REF;
        end
      end
      S_PREA: begin
        if (cmd_ready_i) begin
          state_d = S_WAIT_RP;
          cnt_d   = CNT_W'(T_RP - 1);
        end
      end
      S_WAIT_RP: begin
        if (cnt_q == '0) state_d = S_REF;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_REF: begin
        if (cmd_ready_i) begin
          state_d = S_WAIT_RFC;
          cnt_d   = CNT_W'(T_RFC - 1);
        end
      end
      S_WAIT_RFC: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they change
  // together with the state they describe and never glitch.
  always_comb begin
    hold_d   = (state_d != S_IDLE);
    valid_d  = (state_d == S_PREA) || (state_d == S_REF);
    is_ref_d = (state_d == S_REF);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      credit_q   <= 5'sd0;
      overflow_q <= 1'b0;
      hold_q     <= 1'b0;
      valid_q    <= 1'b0;
      is_ref_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      credit_q   <= credit_d;
      overflow_q <= overflow_d;
      hold_q     <= hold_d;
      valid_q    <= valid_d;
      is_ref_q   <= is_ref_d;
    end
  end

  assign hold_o       = hold_q;
  assign ref_busy_o   = hold_q;
  assign cmd_valid_o  = valid_q;
  assign cmd_is_ref_o = is_ref_q;
  assign credit_o     = credit_q;
  assign overflow_o   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_refresh_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_refresh_sequencer
// Purpose  : Self-checking bench for refresh_sequencer. Table-driven cycle
//            vectors for the basic refresh and forced/overflow paths, plus
//            hand-written sequences for PREA timing, handshake stability,
//            tick/accept collision, asynchronous reset and pull-in.
// Revision : 1.0 - initial release
// ============================================================================
module tb_refresh_sequencer;

  localparam int T_RP  = 6;
  localparam int T_RFC = 88;

  logic              clk;
  logic              rst;
  logic              ref_tick;
  logic              sched_idle;
  logic [7:0]        bank_open;
  logic              hold;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_is_ref;
  logic              ref_busy;
  logic signed [4:0] credit;
  logic              overflow;

  int total;
  int bad;

  refresh_sequencer #(
    .NBANK(8), .T_RP(T_RP), .T_RFC(T_RFC),
    .MAX_POSTPONE(8), .MAX_PULLIN(8), .IDLE_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .ref_tick_i(ref_tick), .sched_idle_i(sched_idle), .bank_open_i(bank_open),
    .hold_o(hold), .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready),
    .cmd_is_ref_o(cmd_is_ref), .ref_busy_o(ref_busy),
    .credit_o(credit), .overflow_o(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              tick;
    logic              idle;
    logic [7:0]        bank;
    logic              ready;
    logic              e_hold;
    logic              e_valid;
    logic              e_ref;
    logic signed [4:0] e_credit;
    logic              e_ovf;
    string             name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic t, input logic i, input logic [7:0] b, input logic r,
                     input logic h, input logic v, input logic rf,
                     input logic signed [4:0] c, input logic o, input string n);
    vec_t x;
    x.tick = t; x.idle = i; x.bank = b; x.ready = r;
    x.e_hold = h; x.e_valid = v; x.e_ref = rf; x.e_credit = c; x.e_ovf = o;
    x.name = n;
    vecs.push_back(x);
  endtask

  // Packed view of every output: {hold, valid, is_ref, busy, overflow, credit}.
  function automatic logic [31:0] outs();
    return {22'b0, hold, cmd_valid, cmd_is_ref, ref_busy, overflow, credit};
  endfunction

  function automatic logic [31:0] expv(input logic h, input logic v, input logic r,
                                       input logic o, input logic signed [4:0] c);
    return {22'b0, h, v, r, h, o, c};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      ref_tick   = vecs[k].tick;
      sched_idle = vecs[k].idle;
      bank_open  = vecs[k].bank;
      cmd_ready  = vecs[k].ready;
      step();
      check(vecs[k].name, outs(),
            expv(vecs[k].e_hold, vecs[k].e_valid, vecs[k].e_ref, vecs[k].e_ovf, vecs[k].e_credit));
    end
  endtask

  // Number of further clock edges until hold drops (bounded).
  task automatic edges_until_hold_low(output int n);
    n = 0;
    while (hold !== 1'b0 && n < 300) begin
      step();
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int refs;
    logic stable;
    logic signed [4:0] exp_credit;

    total = 0;
    bad   = 0;

    // Scenario 1: single REF from credit 0, banks closed, zero-wait ready.
    add(1, 1, 8'h00, 1,  0, 0, 0, 5'sd1, 0, "s1_tick");
    add(0, 1, 8'h00, 1,  1, 0, 0, 5'sd1, 0, "s1_drain");
    add(0, 1, 8'h00, 1,  1, 1, 1, 5'sd1, 0, "s1_ref_valid");
    add(0, 1, 8'h00, 1,  1, 0, 0, 5'sd0, 0, "s1_ref_accept");
    // Scenario 3: scheduler busy, eight ticks force a refresh, ninth overflows.
    for (int k = 1; k <= 8; k++)
      add(1, 0, 8'h00, 0, 0, 0, 0, 5'(k), 0, $sformatf("s3_tick%0d", k));
    add(0, 0, 8'h00, 0,  1, 0, 0, 5'sd8, 0, "s3_forced_drain");
    add(0, 0, 8'h00, 0,  1, 0, 0, 5'sd8, 0, "s3_drain_wait");
    add(1, 0, 8'h00, 0,  1, 0, 0, 5'sd8, 1, "s3_overflow");
    add(0, 1, 8'h00, 0,  1, 1, 1, 5'sd8, 1, "s3_ref_valid");
    add(0, 1, 8'h00, 1,  1, 0, 0, 5'sd7, 1, "s3_ref_accept");

    // Reset state.
    rst = 1'b1; ref_tick = 0; sched_idle = 0; bank_open = '0; cmd_ready = 0;
    step();
    step();
    check("reset_state", outs(), 32'd0);
    rst = 1'b0;

    run_rows(0, 3);
    edges_until_hold_low(n);
    check("s1_rfc_len", 32'(n), 32'(T_RFC));

    // Scenario 2: open bank forces PREA before REF.
    ref_tick = 1; sched_idle = 1; bank_open = 8'h04; cmd_ready = 0;
    step(); check("s2_tick", outs(), expv(0, 0, 0, 0, 5'sd1));
    ref_tick = 0;
    step(); check("s2_drain", outs(), expv(1, 0, 0, 0, 5'sd1));
    step(); check("s2_prea_valid", outs(), expv(1, 1, 0, 0, 5'sd1));
    step(); check("s2_prea_held", outs(), expv(1, 1, 0, 0, 5'sd1));
    cmd_ready = 1;
    step(); n = 1;
    check("s2_prea_drop", outs(), expv(1, 0, 0, 0, 5'sd1));
    cmd_ready = 0;
    while (cmd_valid !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check("s2_rp_gap", 32'(n), 32'(T_RP + 1));
    check("s2_ref_valid", outs(), expv(1, 1, 1, 0, 5'sd1));
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      if (!(cmd_valid === 1'b1 && cmd_is_ref === 1'b1)) stable = 1'b0;
    end
    check("s2_ref_stable", 32'(stable), 32'd1);
    cmd_ready = 1;
    step(); check("s2_ref_accept", outs(), expv(1, 0, 0, 0, 5'sd0));
    bank_open = '0;
    edges_until_hold_low(n);
    check("s2_rfc_len", 32'(n), 32'(T_RFC));

    run_rows(4, vecs.size() - 1);

    // Scenario 6: asynchronous reset in the middle of WAIT_RFC.
    ref_tick = 0; sched_idle = 0; cmd_ready = 0;
    for (int k = 0; k < 10; k++) step();
    #2 rst = 1'b1;
    #1 check("rst_async", outs(), 32'd0);
    step();
    rst = 1'b0;

    // Scenario 4: tick coinciding with REF acceptance at credit 3.
    ref_tick = 1;
    for (int k = 0; k < 3; k++) step();
    check("s4_credit3", outs(), expv(0, 0, 0, 0, 5'sd3));
    ref_tick = 0; sched_idle = 1; cmd_ready = 1;
    step(); check("s4_drain", outs(), expv(1, 0, 0, 0, 5'sd3));
    step(); check("s4_ref_valid", outs(), expv(1, 1, 1, 0, 5'sd3));
    ref_tick = 1;
    step(); check("s4_accept_tick", outs(), expv(1, 0, 0, 0, 5'sd3));
    ref_tick = 0;

    // Scenario 5: long idle run, no ticks.
    #2 rst = 1'b1;
    step();
    rst = 1'b0;
    sched_idle = 1; cmd_ready = 1; ref_tick = 0; bank_open = '0;
    refs = 0;
    for (int k = 0; k < 1200; k++) begin
      step();
      if (cmd_valid === 1'b1 && cmd_is_ref === 1'b1) refs++;
    end
`ifdef REFRESH_PULL_IN_EN
    exp_credit = -5'sd8;
    check("s5_refs", 32'(refs), 32'd8);
`else
    exp_credit = 5'sd0;
    check("s5_refs", 32'(refs), 32'd0);
`endif
    check("s5_credit", {27'b0, credit}, {27'b0, exp_credit});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/refresh_sequencer.md
# refresh_sequencer

Sequences DRAM auto-refresh in the controller clock domain. It keeps a signed refresh credit that `ref_tick` raises once per tREFI and each issued REF lowers. It decides when a refresh must or may run, holds off the scheduler, and closes open banks with PREA. It then issues REF to the command generator over a valid/ready handshake and enforces tRP and tRFC. It sits between the tREFI timer and the command generator, alongside the scheduler.

## Interface
Parameters:
- `NBANK`, 8: number of banks tracked in `bank_open`.
- `T_RP`, 6: cycles from PREA acceptance to REF eligibility.
- `T_RFC`, 88: cycles from REF acceptance to return to IDLE.
- `MAX_POSTPONE`, 8: credit at which refresh is forced; also the saturation limit.
- `MAX_PULLIN`, 8: maximum refreshes issued ahead of schedule.
- `IDLE_CYCLES`, 16: consecutive idle cycles required before a pull-in.

Ports:
- `clk`  in  1  controller clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `ref_tick`  in  1  one-cycle pulse per tREFI elapsed.
- `sched_idle`  in  1  scheduler has no command in flight or pending.
- `bank_open`  in  NBANK  per-bank open-row flags.
- `hold`  out  1  scheduler must not issue new commands.
- `cmd_valid`  out  1  refresh-path command request.
- `cmd_ready`  in  1  command generator accepts the command this cycle.
- `cmd_is_ref`  out  1  1 = REF, 0 = PREA (precharge all).
- `ref_busy`  out  1  high in every state except IDLE.
- `credit`  out  5  signed credit, range -MAX_PULLIN..+MAX_POSTPONE.
- `overflow`  out  1  sticky flag: a tick arrived while credit was saturated.

## Operation
- Reset values: state IDLE, credit 0, all outputs 0, counters 0.
- Credit update per cycle: `+1` on `ref_tick`, `-1` on an accepted REF. Both in the same cycle leave credit unchanged.
- Tick with credit = MAX_POSTPONE and no REF accepted: credit stays at MAX_POSTPONE; `overflow` sets. It clears only on `rst`.
- States and transitions:
  - IDLE -> DRAIN when any one of:
    - credit == MAX_POSTPONE (forced);
    - credit >= 1 and `sched_idle`;
    - pull-in: credit > -MAX_PULLIN and `sched_idle` for IDLE_CYCLES consecutive cycles.
  - DRAIN: `hold`=1. Wait for `sched_idle`. Then go to PREA if `bank_open` != 0, else to REF.
  - PREA: `cmd_valid`=1, `cmd_is_ref`=0 until `cmd_ready`. On acceptance go to WAIT_RP and load the counter with T_RP-1.
  - WAIT_RP: decrement the counter; at 0 go to REF.
  - REF: `cmd_valid`=1, `cmd_is_ref`=1 until `cmd_ready`. On acceptance decrement credit, load the counter with T_RFC-1, go to WAIT_RFC.
  - WAIT_RFC: decrement the counter; at 0 go to IDLE.
- `hold`=1 in every state except IDLE.
- While `cmd_valid`=1, `cmd_is_ref` must not change. `cmd_valid` drops in the cycle after acceptance.
- The idle-run counter resets whenever `sched_idle`=0 or state != IDLE. It saturates at IDLE_CYCLES.
- `ref_tick` is counted in every state, including during WAIT_RFC.
- One REF per pass through the state machine. Remaining positive credit re-triggers from IDLE on a later cycle.
- `rst` mid-sequence aborts immediately, with no completion of an outstanding PREA or REF. Re-initialising the DRAM after such a reset is the caller's responsibility.

## Timing
- All outputs are registered. The IDLE->DRAIN decision is made on cycle N; `hold` and `ref_busy` go high on N+1.
- DRAIN exits on the first cycle `sched_idle`=1 is sampled. `cmd_valid` rises on the following cycle.
- PREA acceptance to REF `cmd_valid`: T_RP+1 cycles.
- REF acceptance to IDLE: T_RFC cycles; `hold` drops with the IDLE entry.
- Minimum REF-to-REF spacing: T_RFC+3 cycles (IDLE, DRAIN, REF with zero-wait ready).

## Configuration
- `REFRESH_PULL_IN_EN` defined:
  - the pull-in trigger is present;
  - credit may go as low as -MAX_PULLIN.
- `REFRESH_PULL_IN_EN` undefined:
  - no pull-in trigger and no idle-run counter;
  - credit lower bound is 0;
  - DRAIN is entered only when credit >= 1.

## Test plan
- Tick with credit 0, `sched_idle`=1, `bank_open`=0, `cmd_ready`=1 -> `hold` on the next cycle, REF accepted, credit back to 0, `hold` low T_RFC cycles after acceptance.
- `bank_open`=8'h04 when refresh triggers -> PREA issued, REF `cmd_valid` T_RP+1 cycles after PREA acceptance, with `cmd_is_ref` stable while `cmd_ready` is held low for 5 cycles.
- `sched_idle`=0 throughout, 8 ticks -> credit 8, forced DRAIN; `cmd_valid` stays low until `sched_idle` rises. A 9th tick before the REF is accepted -> credit remains 8 and `overflow`=1.
- `ref_tick` in the same cycle as REF acceptance at credit 3 -> credit remains 3.
- With `REFRESH_PULL_IN_EN` defined, `sched_idle`=1 for a long run and no ticks -> 8 REFs, credit -8, no further REF. Without the macro, the same stimulus -> no REF and credit 0.
- `rst` asserted in WAIT_RFC -> all outputs 0 asynchronously, credit 0; normal operation resumes after deassertion.
